mux_case: RTL and testbench

Parameterised N:1 selector, one data lane of DATA_W bits per input. It produces a combinational output and a registered copy of that output. It is used wherever a small case-style lane select is needed, and in single-bit control muxing. The default configuration is a 4:1 mux of 1-bit inputs packed into a 4-bit bus.

---
 rtl/mux_pkg.sv | 11 +
 rtl/mux_out_reg.sv | 21 ++
 rtl/mux_case.sv | 65 ++++++
 tb/tb_mux_case.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the mux_case selector.
// Provides the select-width derivation and the out-of-range data value.
package mux_pkg;

    localparam int MUX_DEFAULT_DATA = 0;

    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_out_reg.sv
// mux_out_reg: DATA_W-wide D flop, async active-high reset to zero.
// Holds the registered copy of the selected lane.
module mux_out_reg #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Capture d every rising edge; clear immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mux_case.sv
// mux_case: N:1 lane selector, combinational out plus registered out_q.
// Define MUX_CASE_SEL_ERR_EN to add the registered sel_err flag.
module mux_case
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 1,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DATA_W-1:0] in,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out,
    output logic [DATA_W-1:0]        out_q
`ifdef MUX_CASE_SEL_ERR_EN
    ,
    output logic                     sel_err
`endif
);

    // Lane select; unmatched select values fall back to the default data.
    always_comb begin
        out = DATA_W'(MUX_DEFAULT_DATA);
        for (int k = 0; k < NUM_IN; k++) begin
            case (sel)
                SEL_W'(k): out = in[k*DATA_W +: DATA_W];
                default: ;
            endcase
        end
    end

    mux_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk(clk),
        .rst(rst),
        .d  (out),
        .q  (out_q)
    );

`ifdef MUX_CASE_SEL_ERR_EN
    localparam bit SEL_POW2 = ((1 << SEL_W) == NUM_IN);

    logic sel_oob;

    // Out-of-range select is impossible when NUM_IN fills the select space.
    always_comb begin
        sel_oob = 1'b0;
        if (!SEL_POW2) begin
            sel_oob = (32'(sel) >= NUM_IN);
        end
    end

    // Register the out-of-range flag alongside out_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= sel_oob;
        end
    end
`endif

endmodule

// File: tb/tb_mux_case.sv
// tb_mux_case: directed and random checks of three mux_case configs.
// Covers 4x1, 3x8 and 8x4; sel_err checked when MUX_CASE_SEL_ERR_EN set.
module tb_mux_case;

    logic        clk;
    logic        rst;
    logic [3:0]  in0;
    logic [1:0]  sel0;
    logic        out0, q0;
    logic [23:0] in1;
    logic [1:0]  sel1;
    logic [7:0]  out1, q1;
    logic [31:0] in2;
    logic [2:0]  sel2;
    logic [3:0]  out2, q2;
    logic        qe0;
    logic [7:0]  qe1;
    logic [3:0]  qe2;
    logic        ee1;
`ifdef MUX_CASE_SEL_ERR_EN
    logic        e0, e1, e2;
`endif

    int vectors = 0;
    int errs    = 0;

    mux_case u0 (
        .clk(clk), .rst(rst), .in(in0), .sel(sel0),
        .out(out0), .out_q(q0)
`ifdef MUX_CASE_SEL_ERR_EN
        , .sel_err(e0)
`endif
    );

    mux_case #(.NUM_IN(3), .DATA_W(8)) u1 (
        .clk(clk), .rst(rst), .in(in1), .sel(sel1),
        .out(out1), .out_q(q1)
`ifdef MUX_CASE_SEL_ERR_EN
        , .sel_err(e1)
`endif
    );

    mux_case #(.NUM_IN(8), .DATA_W(4)) u2 (
        .clk(clk), .rst(rst), .in(in2), .sel(sel2),
        .out(out2), .out_q(q2)
`ifdef MUX_CASE_SEL_ERR_EN
        , .sel_err(e2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m0(input logic [3:0] d, input logic [1:0] s);
        return 1'((d >> s) & 4'h1);
    endfunction

    function automatic logic [7:0] m1(input logic [23:0] d, input logic [1:0] s);
        if (s >= 2'd3) return 8'h00;
        return 8'(d >> (int'(s) * 8));
    endfunction

    function automatic logic [3:0] m2(input logic [31:0] d, input logic [2:0] s);
        return 4'(d >> (int'(s) * 4));
    endfunction

    // Reference for the registered path: previous cycle's expected out.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qe0 <= 1'b0;
            qe1 <= 8'h00;
            qe2 <= 4'h0;
            ee1 <= 1'b0;
        end else begin
            qe0 <= m0(in0, sel0);
            qe1 <= m1(in1, sel1);
            qe2 <= m2(in2, sel2);
            ee1 <= (sel1 == 2'd3);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("miscompare at %s", tag);
        end
    endtask

    task automatic check_out();
        chk("out0", 32'(out0), 32'(m0(in0, sel0)));
        chk("out1", 32'(out1), 32'(m1(in1, sel1)));
        chk("out2", 32'(out2), 32'(m2(in2, sel2)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("out_q0", 32'(q0), 32'(qe0));
        chk("out_q1", 32'(q1), 32'(qe1));
        chk("out_q2", 32'(q2), 32'(qe2));
`ifdef MUX_CASE_SEL_ERR_EN
        chk("sel_err0", 32'(e0), 32'd0);
        chk("sel_err1", 32'(e1), 32'(ee1));
        chk("sel_err2", 32'(e2), 32'd0);
`endif
    endtask

    logic [3:0] exp_a [4];
    logic [3:0] exp_b [4];
    logic [7:0] exp_c [4];

    initial begin
        exp_a = '{4'd1, 4'd1, 4'd0, 4'd0};
        exp_b = '{4'd0, 4'd1, 4'd0, 4'd1};
        exp_c = '{8'hA5, 8'h5A, 8'hC3, 8'h00};
        rst  = 1'b1;
        in0  = 4'b0011;
        sel0 = 2'd0;
        in1  = 24'h0;
        sel1 = 2'd0;
        in2  = 32'h0;
        sel2 = 3'd0;
        #2;
        chk("rst_q0", 32'(q0), 32'd0);
        chk("rst_q1", 32'(q1), 32'd0);
        chk("rst_q2", 32'(q2), 32'd0);
        chk("rst_out0", 32'(out0), 32'd1);
        tick();
        tick();
        chk("rst_hold_q0", 32'(q0), 32'd0);
        #2 rst = 1'b0;
        tick();

        // Default config, in=0011, stepped select.
        for (int s = 0; s < 4; s++) begin
            sel0 = 2'(s);
            #2;
            chk("dflt_0011", 32'(out0), 32'(exp_a[s]));
            check_out();
            tick();
            chk("dflt_0011_q", 32'(q0), 32'(exp_a[s]));
        end

        // in=1010 sweep, then lane data change without a clock edge.
        in0 = 4'b1010;
        for (int s = 0; s < 4; s++) begin
            sel0 = 2'(s);
            #2;
            chk("dflt_1010", 32'(out0), 32'(exp_b[s]));
            tick();
        end
        sel0 = 2'd3;
        #1;
        chk("pre_drop", 32'(out0), 32'd1);
        in0 = 4'b0101;
        #1;
        chk("no_clk_drop", 32'(out0), 32'd0);
        tick();

        // 3x8 lanes including the out-of-range select.
        in1 = {8'hC3, 8'h5A, 8'hA5};
        for (int s = 0; s < 4; s++) begin
            sel1 = 2'(s);
            #2;
            chk("n3_out", 32'(out1), 32'(exp_c[s]));
            tick();
        end
`ifdef MUX_CASE_SEL_ERR_EN
        chk("sel_err_set", 32'(e1), 32'd1);
`endif
        sel1 = 2'd0;
        tick();
`ifdef MUX_CASE_SEL_ERR_EN
        chk("sel_err_clr", 32'(e1), 32'd0);
`endif

        // Mid-cycle reset pulse with out_q holding 1.
        in0  = 4'b1111;
        sel0 = 2'd0;
        tick();
        chk("pre_rst_q0", 32'(q0), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q0", 32'(q0), 32'd0);
        chk("async_rst_out0", 32'(out0), 32'd1);
        tick();
        chk("rst_held_q0", 32'(q0), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("rel_q0", 32'(q0), 32'd0);
        tick();
        chk("post_rst_q0", 32'(q0), 32'd1);

        // Random traffic on all three configurations.
        for (int i = 0; i < 1000; i++) begin
            in0  = 4'($urandom);
            sel0 = 2'($urandom_range(0, 3));
            in1  = 24'($urandom);
            sel1 = 2'($urandom_range(0, 3));
            in2  = $urandom;
            sel2 = 3'($urandom_range(0, 7));
            #2;
            check_out();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

endmodule
